ps2_mouse_init_ctrl: RTL and testbench

//  Sequences PS/2 mouse bring-up via the host-to-mouse transmitter and the byte receiver.

---
 rtl/ps2_mouse_init_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_init_ctrl
//
// Brings a PS/2 mouse up through the host-to-mouse transmitter and the byte
// receiver. The bring-up sequence is:
//   1. Send Reset (0xFF). Expect ACK 0xFA, then BAT 0xAA, then ID 0x00.
//   2. Send Enable Data Reporting (0xF4). Expect ACK 0xFA.
//   3. Raise init_done so that later rx bytes are treated as stream packets.
// A 0xFE reply resends the same command. A bad reply or a timeout restarts
// the whole sequence, up to MAX_RETRY times, and then the block parks in
// ERROR. This block is the only driver of the transmitter en/din.
//
// Handshake: tx_en is a one-cycle request to the transmitter, and tx_data is
// held stable from tx_en until tx_finish. tx_finish and rx_valid are
// one-cycle pulses from their sources, so there is no backpressure. This
// block only reacts to them in the states that expect them.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   start      : rising edge (re)starts the sequence; accepted when not busy
//   tx_en      : one-cycle pulse to the transmitter enable
//   tx_data    : command byte to the transmitter
//   tx_finish  : transmitter finished the byte (pulse)
//   rx_valid   : rx_data holds a received byte (pulse)
//   rx_data    : byte received from the mouse
//   busy       : sequence in progress
//   init_done  : sequence completed; rx bytes are stream packets
//   init_error : retries exhausted
//   retry_cnt  : full-sequence restarts used so far (saturating)
//   fsm_state  : current FSM state encoding, for debug/checkers
// ---------------------------------------------------------------------------
module ps2_mouse_init_ctrl #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_finish,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [1:0] retry_cnt,
  output logic [3:0] fsm_state
);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [CNT_W-1:0] TIMER_END = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SEND     = 4'd1,
    S_WAIT_TX  = 4'd2,
    S_WAIT_ACK = 4'd3,
    S_WAIT_BAT = 4'd4,
    S_WAIT_ID  = 4'd5,
    S_FAIL     = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             start_r;
  logic             start_q;
  logic             start_edge;
  logic [7:0]       cmd_next;
  logic [1:0]       retry_next;
  logic [CNT_W-1:0] timer;
  logic             timer_expired;
  logic             waiting;

  // start goes through one register stage before edge detection, so the
  // edge is taken from two registered copies of start.
  assign start_edge    = start_r & ~start_q;
  assign timer_expired = (timer == TIMER_END);
  assign waiting       = (state == S_WAIT_TX) || (state == S_WAIT_ACK) ||
                         (state == S_WAIT_BAT) || (state == S_WAIT_ID);

  // State register, command byte, retry counter and timeout timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      start_r   <= 1'b0;
      start_q   <= 1'b0;
      tx_data   <= 8'h00;
      retry_cnt <= 2'd0;
      timer     <= '0;
    end else begin
      state     <= state_next;
      start_r   <= start;
      start_q   <= start_r;
      // The command byte is loaded on entry to SEND, so it is already
      // valid in the tx_en cycle and holds until the next command.
      tx_data   <= cmd_next;
      retry_cnt <= retry_next;
      if (state_next != state) begin
        timer <= '0;
      end else if (waiting) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Next-state logic. In each wait state a response event is tested before
  // the timeout, so an event in the final timer cycle still counts.
  always_comb begin
    state_next = state;
    cmd_next   = tx_data;
    retry_next = retry_cnt;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_edge) begin
          state_next = S_SEND;
          cmd_next   = CMD_RESET;
          retry_next = 2'd0;
        end
      end
      S_SEND: begin
        state_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_finish) begin
          state_next = S_WAIT_ACK;
        end else if (timer_expired) begin
          state_next = S_FAIL;
        end
      end
      S_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == RSP_ACK) begin
            state_next = (tx_data == CMD_RESET) ? S_WAIT_BAT : S_DONE;
          end else if (rx_data == RSP_RESEND) begin
            // Resend the same command. Leaving WAIT_ACK restarts the timer.
            state_next = S_SEND;
          end else begin
            state_next = S_FAIL;
          end
        end else if (timer_expired) begin
          state_next = S_FAIL;
        end
      end
      S_WAIT_BAT: begin
        if (rx_valid) begin
          state_next = (rx_data == RSP_BAT_OK) ? S_WAIT_ID : S_FAIL;
        end else if (timer_expired) begin
          state_next = S_FAIL;
        end
      end
      S_WAIT_ID: begin
        if (rx_valid) begin
          if (rx_data == RSP_ID) begin
            state_next = S_SEND;
            cmd_next   = CMD_ENABLE;
          end else begin
            state_next = S_FAIL;
          end
        end else if (timer_expired) begin
          state_next = S_FAIL;
        end
      end
      S_FAIL: begin
        if (retry_cnt < RETRY_MAX) begin
          state_next = S_SEND;
          cmd_next   = CMD_RESET;
          retry_next = retry_cnt + 2'd1;
        end else begin
          state_next = S_ERROR;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign tx_en      = (state == S_SEND);
  assign busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign init_done  = (state == S_DONE);
  assign init_error = (state == S_ERROR);
  assign fsm_state  = state;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_mouse_init_ctrl;

  localparam int TO = 1000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_finish = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       init_done;
  logic       init_error;
  logic [1:0] retry_cnt;
  logic [3:0] fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (3),
    .CNT_W      (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_finish (tx_finish),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy),
    .init_done (init_done),
    .init_error(init_error),
    .retry_cnt (retry_cnt),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int tx_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Every tx_en pulse pops the next expected command byte.
  always @(negedge clk) begin
    if (!rst && tx_en) begin
      tx_pulses++;
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1 tx_finish = 1'b1;
    @(posedge clk); #1 tx_finish = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  // Returns at the negedge where tx_en is seen high.
  task automatic wait_tx_en(input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (tx_en) break;
      n++;
      if (n >= budget) begin
        check("tx_en_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_not_busy(input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n >= budget) begin
        check("busy_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // Called right after the 0xFF tx_en: answer ACK, BAT, ID, then ACK the 0xF4.
  task automatic nominal_tail();
    pulse_finish();
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    @(negedge clk);
    check("resp_to_tx_lat", {31'd0, tx_en}, 32'd1);
    pulse_finish();
    send_rx(8'hFA);
    wait_not_busy(20);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int p0;
    int t_prev;
    int gap;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en",      {31'd0, tx_en},      32'd0);
    check("rst_tx_data",    {24'd0, tx_data},    32'h00);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_init_done",  {31'd0, init_done},  32'd0);
    check("rst_init_error", {31'd0, init_error}, 32'd0);
    check("rst_retry_cnt",  {30'd0, retry_cnt},  32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // T1 nominal, with a stray rx byte during WAIT_TX that must be dropped
    p0 = tx_pulses;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF4);
    do_start();
    @(negedge clk);
    check("start_lat_early", {31'd0, tx_en}, 32'd0);
    @(negedge clk);
    check("start_lat", {31'd0, tx_en}, 32'd1);
    send_rx(8'hFA);
    nominal_tail();
    check("t1_done",   {31'd0, init_done}, 32'd1);
    check("t1_busy",   {31'd0, busy},      32'd0);
    check("t1_retry",  {30'd0, retry_cnt}, 32'd0);
    check("t1_pulses", tx_pulses - p0,     32'd2);
    check("t1_q",      exp_q.size(),       32'd0);

    // T6 restart from DONE; start edge during WAIT_ACK is ignored
    p0 = tx_pulses;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF4);
    do_start();
    wait_tx_en(10);
    check("t6_done_drop", {31'd0, init_done}, 32'd0);
    check("t6_busy",      {31'd0, busy},      32'd1);
    pulse_finish();
    do_start();
    repeat (4) @(negedge clk);
    check("t6_busy_after_start", {31'd0, busy}, 32'd1);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_tx_en(5);
    pulse_finish();
    send_rx(8'hFA);
    wait_not_busy(20);
    check("t6_done",   {31'd0, init_done}, 32'd1);
    check("t6_pulses", tx_pulses - p0,     32'd2);
    check("t6_q",      exp_q.size(),       32'd0);

    // T2 resend
    p0 = tx_pulses;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF4);
    do_start();
    wait_tx_en(10);
    pulse_finish();
    send_rx(8'hFE);
    wait_tx_en(5);
    nominal_tail();
    check("t2_done",   {31'd0, init_done}, 32'd1);
    check("t2_retry",  {30'd0, retry_cnt}, 32'd0);
    check("t2_pulses", tx_pulses - p0,     32'd3);
    check("t2_q",      exp_q.size(),       32'd0);

    // T4 bad BAT then recovery
    p0 = tx_pulses;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF4);
    do_start();
    wait_tx_en(10);
    pulse_finish();
    send_rx(8'hFA);
    send_rx(8'hFC);
    wait_tx_en(5);
    check("t4_retry_mid", {30'd0, retry_cnt}, 32'd1);
    nominal_tail();
    check("t4_done",   {31'd0, init_done}, 32'd1);
    check("t4_retry",  {30'd0, retry_cnt}, 32'd1);
    check("t4_pulses", tx_pulses - p0,     32'd3);
    check("t4_q",      exp_q.size(),       32'd0);

    // T3 timeout: tx_finish never arrives
    p0 = tx_pulses;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    do_start();
    wait_tx_en(10);
    t_prev = cyc;
    for (int i = 1; i < 4; i++) begin
      wait_tx_en(TO + 20);
      gap = cyc - t_prev;
      check("t3_gap", {31'd0, (gap >= TO && gap <= TO + 3)}, 32'd1);
      t_prev = cyc;
    end
    wait_not_busy(TO + 20);
    check("t3_error",  {31'd0, init_error}, 32'd1);
    check("t3_done",   {31'd0, init_done},  32'd0);
    check("t3_retry",  {30'd0, retry_cnt},  32'd3);
    check("t3_busy",   {31'd0, busy},       32'd0);
    check("t3_pulses", tx_pulses - p0,      32'd4);
    check("t3_q",      exp_q.size(),        32'd0);

    // T5 async reset in WAIT_BAT (after one retry), then stray inputs
    p0 = tx_pulses;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    do_start();
    wait_tx_en(10);
    check("t5_error_clr", {31'd0, init_error}, 32'd0);
    pulse_finish();
    send_rx(8'hFA);
    send_rx(8'hFC);
    wait_tx_en(5);
    pulse_finish();
    send_rx(8'hFA);
    check("t5_retry_pre", {30'd0, retry_cnt}, 32'd1);
    check("t5_busy_pre",  {31'd0, busy},      32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_busy",    {31'd0, busy},       32'd0);
    check("t5_rst_retry",   {30'd0, retry_cnt},  32'd0);
    check("t5_rst_tx_data", {24'd0, tx_data},    32'h00);
    check("t5_rst_tx_en",   {31'd0, tx_en},      32'd0);
    check("t5_rst_done",    {31'd0, init_done},  32'd0);
    check("t5_rst_error",   {31'd0, init_error}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    pulse_finish();
    send_rx(8'hAA);
    send_rx(8'h00);
    repeat (5) @(negedge clk);
    check("t5_stray_busy",   {31'd0, busy},      32'd0);
    check("t5_stray_done",   {31'd0, init_done}, 32'd0);
    check("t5_stray_pulses", tx_pulses - p0,     32'd2);
    check("t5_q",            exp_q.size(),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
